// File: rtl/xgen_pkg.sv
// Shared constants, offset table and entry indexing for the link transform pipeline.
// Latency: n/a (package only).
// Backpressure: n/a.
package xgen_pkg;

    localparam int WIDTH        = 32;
    localparam int DECIMAL_BITS = 16;
    localparam int NUM_LINKS    = 7;
    localparam int LINK_W       = $clog2(NUM_LINKS);
    localparam int NUM_ENT      = 15;

    localparam logic signed [WIDTH-1:0] ONE     = WIDTH'(1) << DECIMAL_BITS;
    localparam logic signed [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // Per-link joint offsets in Q.DECIMAL_BITS. Link 6 is the full-scale
    // offset, which drives the multipliers into saturation.
    localparam logic signed [WIDTH-1:0] LINK_OFFSET [NUM_LINKS] = '{
        32'sd20000, 32'sd13402, 32'sd26500, -32'sd13402,
        32'sd65536, -32'sd32768, 32'sh7FFF_FFFF
    };

    typedef enum logic [3:0] {
        E_AX_AX, E_AX_AY, E_AX_AZ, E_AY_AX, E_AY_AY,
        E_AY_AZ, E_AZ_AY, E_AZ_AZ, E_LX_AX, E_LX_AY,
        E_LX_AZ, E_LY_AX, E_LY_AY, E_LY_AZ, E_LZ_AX
    } entry_e;

    typedef logic [NUM_ENT-1:0][WIDTH-1:0] xform_t;

    // Out-of-range indices return 0 so downstream products come out as 0.
    function automatic logic signed [WIDTH-1:0] link_offset(input logic [LINK_W-1:0] link);
        logic signed [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_LINKS; i++) begin
            if (int'(link) == i) r = LINK_OFFSET[i];
        end
        return r;
    endfunction

    // Negation that maps the most negative value onto the most positive one.
    function automatic logic signed [WIDTH-1:0] neg_sat(input logic signed [WIDTH-1:0] x);
        return (x == SAT_MIN) ? SAT_MAX : -x;
    endfunction

endpackage

// File: rtl/xgen_if.sv
// Sample-in / transform-out stream bundle for xgen_pipe (valid/ready on both sides).
// Latency: n/a (wiring only).
// Backpressure: in_ready and out_ready carry the stalls.
// Ports: slave = block side, master = producer/consumer side.
interface xgen_if;
    import xgen_pkg::*;

    logic                     in_valid;
    logic                     in_ready;
    logic signed [WIDTH-1:0]  sinq_in;
    logic signed [WIDTH-1:0]  cosq_in;
    logic [LINK_W-1:0]        link_in;
    logic                     out_valid;
    logic                     out_ready;
    logic [LINK_W-1:0]        link_out;
    logic                     err_out;
    xform_t                   xform_out;

    modport slave (
        input  in_valid, sinq_in, cosq_in, link_in, out_ready,
        output in_ready, out_valid, link_out, err_out, xform_out
    );

    modport master (
        output in_valid, sinq_in, cosq_in, link_in, out_ready,
        input  in_ready, out_valid, link_out, err_out, xform_out
    );
endinterface

// File: rtl/sat_cmult.sv
// Registered signed coef*x, floor-shifted by DECIMAL_BITS and saturated to WIDTH.
// Latency: 1 cycle (prod_o updates on the edge where en_i is high).
// Backpressure: prod_o holds whenever en_i is low.
// Ports: clk, rst_n, en_i, coef_i, x_i -> prod_o.
module sat_cmult
    import xgen_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en_i,
    input  logic signed [WIDTH-1:0] coef_i,
    input  logic signed [WIDTH-1:0] x_i,
    output logic signed [WIDTH-1:0] prod_o
);
    logic signed [2*WIDTH-1:0] full;
    logic signed [2*WIDTH-1:0] shr;
    logic signed [WIDTH-1:0]   prod_d;
    logic signed [WIDTH-1:0]   prod_q;

    always_comb begin
        full = (2*WIDTH)'(coef_i) * (2*WIDTH)'(x_i);
        shr  = full >>> DECIMAL_BITS;
        // Fits in WIDTH only when the bits above the result sign all agree.
        if ((&shr[2*WIDTH-1:WIDTH-1]) || ~(|shr[2*WIDTH-1:WIDTH-1])) begin
            prod_d = shr[WIDTH-1:0];
        end else if (shr[2*WIDTH-1]) begin
            prod_d = SAT_MIN;
        end else begin
            prod_d = SAT_MAX;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
        end else if (en_i) begin
            prod_q <= prod_d;
        end
    end

    assign prod_o = prod_q;
endmodule

// File: rtl/xgen_pipe.sv
// Two-stage pipeline turning (sin, cos, link) into the 15 sparse 6x6 transform entries.
// Latency: 2 cycles, 1 sample/cycle sustained.
// Backpressure: out_ready low stalls S2, then S1; in_ready drops when both hold data.
// Ports: clk, rst_n, bus (xgen_if.slave: sample in, entries/link/err out).
module xgen_pipe
    import xgen_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    xgen_if.slave  bus
);
    logic adv1, adv2, in_fire, en2, link_err;

    logic                    v1_q, s1_err_q;
    logic signed [WIDTH-1:0] s1_s_q, s1_c_q, s1_d_q;
    logic [LINK_W-1:0]       s1_link_q;

    logic                    v2_q, s2_err_q;
    logic [LINK_W-1:0]       s2_link_q;
    logic signed [WIDTH-1:0] s2_s_q, s2_c_q, s2_nc_q;
    logic signed [WIDTH-1:0] p_ds, p_dc;

    xform_t xf;

    // A stage may load when it is empty or its contents move on this cycle.
    assign adv2     = !v2_q || bus.out_ready;
    assign adv1     = !v1_q || adv2;
    assign in_fire  = bus.in_valid && adv1;
    assign en2      = adv2 && v1_q;
    assign link_err = int'(bus.link_in) >= NUM_LINKS;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q      <= 1'b0;
            s1_s_q    <= '0;
            s1_c_q    <= '0;
            s1_d_q    <= '0;
            s1_link_q <= '0;
            s1_err_q  <= 1'b0;
        end else begin
            if (adv1) v1_q <= bus.in_valid;
            if (in_fire) begin
                s1_s_q    <= bus.sinq_in;
                s1_c_q    <= bus.cosq_in;
                s1_d_q    <= link_offset(bus.link_in);
                s1_link_q <= bus.link_in;
                s1_err_q  <= link_err;
            end
        end
    end

    // A bad link carries d=0, so the products clear themselves; only the
    // trig-derived entries need explicit masking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q      <= 1'b0;
            s2_link_q <= '0;
            s2_err_q  <= 1'b0;
            s2_s_q    <= '0;
            s2_c_q    <= '0;
            s2_nc_q   <= '0;
        end else begin
            if (adv2) v2_q <= v1_q;
            if (en2) begin
                s2_link_q <= s1_link_q;
                s2_err_q  <= s1_err_q;
                s2_s_q    <= s1_err_q ? '0 : s1_s_q;
                s2_c_q    <= s1_err_q ? '0 : s1_c_q;
                s2_nc_q   <= s1_err_q ? '0 : neg_sat(s1_c_q);
            end
        end
    end

    sat_cmult u_mul_ds (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (en2),
        .coef_i (s1_d_q),
        .x_i    (s1_s_q),
        .prod_o (p_ds)
    );

    sat_cmult u_mul_dc (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (en2),
        .coef_i (s1_d_q),
        .x_i    (s1_c_q),
        .prod_o (p_dc)
    );

    // Entries are pure functions of S2 registers, so they hold while stalled.
    always_comb begin
        xf          = '0;
        xf[E_AX_AX] = s2_nc_q;
        xf[E_AX_AZ] = s2_s_q;
        xf[E_AY_AX] = s2_s_q;
        xf[E_AY_AZ] = s2_c_q;
        xf[E_AZ_AY] = (v2_q && !s2_err_q) ? ONE : '0;
        xf[E_LX_AX] = p_ds;
        xf[E_LX_AZ] = p_dc;
        xf[E_LY_AX] = p_dc;
        xf[E_LY_AZ] = neg_sat(p_ds);
    end

    assign bus.in_ready  = adv1;
    assign bus.out_valid = v2_q;
    assign bus.link_out  = s2_link_q;
    assign bus.err_out   = s2_err_q;
    assign bus.xform_out = xf;
endmodule

// File: tb/tb_xgen_pipe.sv
module tb_xgen_pipe;
    import xgen_pkg::*;

    typedef struct packed {
        logic [2:0] link;
        logic       err;
        xform_t     e;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   n_out = 0;
    bit   rnd_done = 0;
    exp_t sb[$];

    xgen_if bus();

    xgen_pipe dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic signed [31:0] tb_off(input logic [2:0] l);
        case (l)
            3'd0: return 32'sd20000;
            3'd1: return 32'sd13402;
            3'd2: return 32'sd26500;
            3'd3: return -32'sd13402;
            3'd4: return 32'sd65536;
            3'd5: return -32'sd32768;
            3'd6: return 32'sh7FFF_FFFF;
            default: return 32'sd0;
        endcase
    endfunction

    function automatic logic [31:0] tb_mul(input logic signed [31:0] d, input logic signed [31:0] x);
        longint p;
        longint q;
        p = longint'(d) * longint'(x);
        q = p >>> 16;
        if (q > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (q < -64'sd2147483648) return 32'h8000_0000;
        return q[31:0];
    endfunction

    function automatic logic [31:0] tb_neg(input logic [31:0] x);
        return (x == 32'h8000_0000) ? 32'h7FFF_FFFF : (32'd0 - x);
    endfunction

    function automatic exp_t mk(input logic [2:0] l, input logic err,
                                input logic [31:0] axax, axaz, ayax, ayaz, azay,
                                input logic [31:0] lxax, lxaz, lyax, lyaz);
        exp_t ex;
        ex = '0;
        ex.link = l;
        ex.err = err;
        ex.e[E_AX_AX] = axax;
        ex.e[E_AX_AZ] = axaz;
        ex.e[E_AY_AX] = ayax;
        ex.e[E_AY_AZ] = ayaz;
        ex.e[E_AZ_AY] = azay;
        ex.e[E_LX_AX] = lxax;
        ex.e[E_LX_AZ] = lxaz;
        ex.e[E_LY_AX] = lyax;
        ex.e[E_LY_AZ] = lyaz;
        return ex;
    endfunction

    function automatic exp_t model(input logic [31:0] s, input logic [31:0] c, input logic [2:0] l);
        logic [31:0] ms, mc;
        if (l >= 3'd7) return mk(l, 1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        ms = tb_mul(tb_off(l), s);
        mc = tb_mul(tb_off(l), c);
        return mk(l, 1'b0, tb_neg(c), s, s, c, 32'd65536, ms, mc, mc, tb_neg(ms));
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Call at posedge+1; returns at posedge+1 after the transfer edge.
    task automatic send(input logic [31:0] s, input logic [31:0] c, input logic [2:0] l, input exp_t ex);
        int guard;
        guard = 0;
        bus.in_valid = 1'b1;
        bus.sinq_in  = s;
        bus.cosq_in  = c;
        bus.link_in  = l;
        @(negedge clk);
        while (!bus.in_ready) begin
            guard++;
            if (guard > 200) begin
                chk("send_timeout", 64'(guard), 64'd0);
                bus.in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk);
        sb.push_back(ex);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 500) begin
            @(negedge clk);
            g++;
        end
        chk("drain_pending", 64'(sb.size()), 64'd0);
    endtask

    // Scoreboard monitor: pops on every output transfer and checks hold stability.
    initial begin : monitor
        exp_t hold;
        exp_t got;
        exp_t ex;
        bit   stalled;
        stalled = 0;
        hold = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 0;
                continue;
            end
            got.link = bus.link_out;
            got.err  = bus.err_out;
            got.e    = bus.xform_out;
            if (stalled) begin
                n_tests++;
                if (got !== hold || !bus.out_valid) begin
                    n_fail++;
                    $display("FAIL hold_stable: outputs changed under stall (valid %0b link %0d err %0b)",
                             bus.out_valid, got.link, got.err);
                end
            end
            if (!bus.out_valid) chk("in_ready_idle", 64'(bus.in_ready), 64'd1);
            if (bus.out_valid && bus.out_ready) begin
                stalled = 0;
                n_out++;
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_out: output #%0d link %0d with empty scoreboard", n_out, got.link);
                end else begin
                    ex = sb.pop_front();
                    if (got !== ex) begin
                        n_fail++;
                        $display("FAIL out_xact #%0d: link %0d/%0d err %0b/%0b (got/expected)",
                                 n_out, got.link, ex.link, got.err, ex.err);
                        for (int k = 0; k < NUM_ENT; k++) begin
                            if (got.e[k] !== ex.e[k])
                                $display("  entry %0d: got 0x%08h expected 0x%08h", k, got.e[k], ex.e[k]);
                        end
                    end
                end
            end else if (bus.out_valid) begin
                stalled = 1;
                hold = got;
            end else begin
                stalled = 0;
            end
        end
    end

    initial begin : watchdog
        #400000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "time limit");
    end

    initial begin : stim
        logic [31:0] rs, rc;
        logic [2:0]  rl;
        bus.in_valid  = 1'b0;
        bus.sinq_in   = '0;
        bus.cosq_in   = '0;
        bus.link_in   = '0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_err", 64'(bus.err_out), 64'd0);
        chk("rst_link", 64'(bus.link_out), 64'd0);
        chk("rst_xform_zero", 64'(|bus.xform_out), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Nominal link 1, accepted on the first edge after release, with latency check
        send(32'd32768, 32'd65536, 3'd1,
             mk(3'd1, 1'b0, -32'sd65536, 32'd32768, 32'd32768, 32'd65536, 32'd65536,
                32'd6701, 32'd13402, 32'd13402, -32'sd6701));
        @(negedge clk);
        chk("lat_s1_not_valid", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        chk("lat_s2_valid", 64'(bus.out_valid), 64'd1);
        @(posedge clk);
        #1;

        // Floor with negative offset, saturation, out-of-range link
        send(32'd1, -32'sd65536, 3'd3,
             mk(3'd3, 1'b0, 32'd65536, 32'd1, 32'd1, -32'sd65536, 32'd65536,
                32'hFFFF_FFFF, 32'd13402, 32'd13402, 32'd1));
        send(32'd0, 32'h7FFF_FFFF, 3'd6,
             mk(3'd6, 1'b0, 32'h8000_0001, 32'd0, 32'd0, 32'h7FFF_FFFF, 32'd65536,
                32'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd0));
        send(32'd0, 32'h8000_0000, 3'd6,
             mk(3'd6, 1'b0, 32'h7FFF_FFFF, 32'd0, 32'd0, 32'h8000_0000, 32'd65536,
                32'd0, 32'h8000_0000, 32'h8000_0000, 32'd0));
        send(32'h8000_0000, 32'd0, 3'd4,
             mk(3'd4, 1'b0, 32'd0, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd65536,
                32'h8000_0000, 32'd0, 32'd0, 32'h7FFF_FFFF));
        send(32'd65536, 32'd65536, 3'd7,
             mk(3'd7, 1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        drain();

        // Backpressure: 4 back-to-back samples with out_ready low for 3 cycles
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        fork
            begin
                send(32'd12345, 32'd54321, 3'd0, model(32'd12345, 32'd54321, 3'd0));
                send(-32'sd40000, 32'd30000, 3'd2, model(-32'sd40000, 32'd30000, 3'd2));
                send(32'd65536, -32'sd1, 3'd5, model(32'd65536, -32'sd1, 3'd5));
                send(32'd777, 32'd888, 3'd4, model(32'd777, 32'd888, 3'd4));
            end
            begin
                @(posedge clk);
                @(posedge clk);
                @(negedge clk);
                chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
                chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two samples in flight
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        send(32'd100, 32'd200, 3'd1, model(32'd100, 32'd200, 3'd1));
        send(32'd300, 32'd400, 3'd2, model(32'd300, 32'd400, 3'd2));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_async_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_async_xform", 64'(|bus.xform_out), 64'd0);
        chk("rst_async_link_err", 64'({bus.link_out, bus.err_out}), 64'd0);
        sb.delete();
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("no_stale_out", 64'(bus.out_valid), 64'd0);
        end

        // Random stream with random out_ready
        @(posedge clk);
        #1;
        fork
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
                bus.out_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    case ($urandom_range(0, 7))
                        0: rs = 32'h7FFF_FFFF;
                        1: rs = 32'h8000_0000;
                        2: rs = 32'd65536;
                        default: rs = $urandom;
                    endcase
                    case ($urandom_range(0, 7))
                        0: rc = 32'h8000_0000;
                        1: rc = -32'sd65536;
                        default: rc = $urandom;
                    endcase
                    rl = 3'($urandom_range(0, 7));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(rs, rc, rl, model(rs, rc, rl));
                end
                drain();
                rnd_done = 1;
            end
        join

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/xgen_pipe.md
# xgen_pipe

Pipelined, multi-link successor to the single-link combinational transform generators. It accepts one (sin q, cos q, link index) sample per cycle and emits the 15 sparse entries of that link's 6x6 spatial transform. Link offsets come from a per-link constant table, and products are saturated. Sits between the sin/cos unit and the RNEA/forward-pass datapath, with valid/ready on both sides so the consumer can stall it.

## Interface
- WIDTH, 32, fixed-point word width (signed).
- DECIMAL_BITS, 16, fractional bits; ONE = 1 << DECIMAL_BITS.
- NUM_LINKS, 7, number of links in the offset table.
- LINK_W, $clog2(NUM_LINKS), width of the link index.
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept the sample this cycle.
- sinq_in, cosq_in  in  WIDTH  signed sin/cos in Qx.DECIMAL_BITS.
- link_in  in  LINK_W  link index of the sample.
- out_valid  out  1  output entries valid.
- out_ready  in  1  consumer accepts the output this cycle.
- link_out  out  LINK_W  link index carried with the result.
- err_out  out  1  link_in was >= NUM_LINKS.
- xform_out_{AX_AX,AX_AY,AX_AZ,AY_AX,AY_AY,AY_AZ,AZ_AY,AZ_AZ,LX_AX,LX_AY,LX_AZ,LY_AX,LY_AY,LY_AZ,LZ_AX}  out  WIDTH each  transform entries.

## Operation
- Input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
- Look up d = LINK_OFFSET[link_in], a signed WIDTH constant.
- Entry equations, with s = sin and c = cos:
  - AX_AX = sat(-c), AX_AZ = s, AY_AX = s, AY_AZ = c.
  - AZ_AY = ONE.
  - LX_AX = m(d,s), LX_AZ = m(d,c), LY_AX = m(d,c), LY_AZ = sat(-m(d,s)).
  - AX_AY = AY_AY = AZ_AZ = LX_AY = LY_AY = LZ_AX = 0.
- Multiply m(d,x):
  - Form the full 2*WIDTH signed product.
  - Arithmetic shift right by DECIMAL_BITS, i.e. floor.
  - Saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- sat(-x): negating the minimum value yields the maximum value.
- Out-of-range link:
  - err_out=1.
  - All 15 entries forced to 0.
  - The sample still flows and consumes a slot.

## Timing
- Two register stages:
  - S1 registers s, c, d, link, err.
  - S2 registers the products and all entries.
- Latency is 2 cycles from input transfer to out_valid with no stall. Throughput is 1 sample/cycle.
- Stall rules:
  - adv2 = !out_valid || out_ready.
  - adv1 = !v1 || adv2.
  - in_ready = adv1, combinational from out_valid/out_ready/v1 and never from in_valid.
- Output stability: while out_valid && !out_ready, every output holds stable.
- No bubbles: sustained in_valid with out_ready=1 gives back-to-back outputs.
- Simultaneous output transfer and a new S1 entry in the same cycle is legal; no data is lost.
- Reset while asserted (rst_n=0):
  - v1, out_valid, err_out and link_out go to 0; all xform_out go to 0.
  - in_ready reads 1 during and after reset.
  - In-flight samples are dropped.
- Reset release: the first input may be accepted in the first clock edge after rst_n rises.

## Structure
- Package xgen_pkg holds:
  - ONE.
  - Saturation bound constants.
  - LINK_OFFSET array, indexed by link, with link 1 = 13402.
  - Entry-index enum for the 15 outputs.
- One sub-module: sat_cmult. It is a registered-output signed multiply with a variable coefficient, floor shift and saturation, and it is instantiated 2x: d*s and d*c. LY_AX reuses the d*c product.

## Test plan
- Nominal link 1, sin=32768, cos=65536, out_ready=1:
  - Output after 2 cycles: LX_AX=6701, LX_AZ=13402, LY_AX=13402, LY_AZ=-6701.
  - AX_AX=-65536, AZ_AY=65536, err_out=0.
- Backpressure:
  - Drive 4 back-to-back samples and hold out_ready=0 for 3 cycles.
  - in_ready must drop once both stages are full. Outputs hold stable.
  - All 4 results emerge in order with no loss or duplication.
- Saturation:
  - Set d = 2^(WIDTH-1)-1 and cos=0x7FFFFFFF. LX_AZ must equal 0x7FFFFFFF.
  - Set cos=0x80000000. AX_AX must equal 0x7FFFFFFF.
- Out-of-range link:
  - Drive link_in=NUM_LINKS.
  - err_out=1, all entries 0, link_out echoes the index.
- Reset mid-flight:
  - Pull rst_n low asynchronously with 2 samples in flight.
  - out_valid drops immediately, before the next clock edge.
  - No stale output appears after release.
- Random stream with random out_ready:
  - Compare every output against a reference model.
  - Check handshake invariants throughout.
